// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I fetch types, opcode constants and redirect helper
package riscv_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_ALU    = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Redirect target before word alignment; jalr clears bit 0 first.
  function automatic logic [31:0] raw_target(input logic [1:0]  src,
                                             input logic [31:0] tgt,
                                             input logic [31:0] alu);
    raw_target = (src == PC_ALU) ? (alu & ~32'h1) : tgt;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO holding {pc, instr} pairs with flush
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rptr];
  assign w_do_push = push && !full && !flush;
  assign w_do_pop  = pop && !empty && !flush;

  // Pointer and occupancy tracking; flush empties the buffer in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  // Storage array; contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV32I fetch stage: PC owner, imem requester, decode buffer
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  input  logic [1:0]  pc_src,
  input  logic [31:0] pc_target,
  input  logic [31:0] alu_result,
  output logic        misalign_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [AW:0]  r_outstanding;
  logic         r_misalign;

  logic [AW:0]  w_fifo_count;
  logic         w_fifo_full;
  logic         w_fifo_empty;
  logic [63:0]  w_fifo_rdata;
  logic         w_redirect;
  logic [31:0]  w_raw_target;
  logic [31:0]  w_target;
  logic         w_credit;
  logic         w_req_hs;
  logic         w_rsp_take;
  logic [AW:0]  w_out_next;
  logic [31:0]  w_rsp_pc;
  logic         w_push;
  logic         w_pop;

  assign w_redirect   = (r_state != IDLE) && ((pc_src == PC_TARGET) || (pc_src == PC_ALU));
  assign w_raw_target = raw_target(pc_src, pc_target, alu_result);
  assign w_target     = {w_raw_target[31:2], 2'b00};

  // Never have more words in flight or buffered than the FIFO can hold.
  assign w_credit   = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < (AW+2)'(FIFO_DEPTH);
  assign w_req_hs   = imem_req_valid && imem_req_ready;
  assign w_rsp_take = imem_rsp_valid && (r_outstanding != '0);
  assign w_out_next = r_outstanding + (AW+1)'(w_req_hs) - (AW+1)'(w_rsp_take);

  // In FETCH the outstanding requests are consecutive words ending at pc-4,
  // so the oldest one (the one responding) sits at pc - 4*outstanding.
  assign w_rsp_pc = r_pc - (32'(r_outstanding) << 2);
  assign w_push   = (r_state == FETCH) && imem_rsp_valid && !w_redirect && !w_fifo_full;
  assign w_pop    = instr_valid && instr_ready;

  assign imem_req_valid = (r_state == FETCH) && w_credit;
  assign imem_req_addr  = r_pc;
  assign misalign_err   = r_misalign;
  assign instr_valid    = !w_fifo_empty;
  assign instr          = instr_valid ? w_fifo_rdata[31:0]           : 32'h0;
  assign instr_pc       = instr_valid ? w_fifo_rdata[63:32]          : 32'h0;
  assign instr_pc_plus4 = instr_valid ? w_fifo_rdata[63:32] + 32'd4 : 32'h0;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (w_redirect),
    .push  (w_push),
    .pop   (w_pop),
    .wdata ({w_rsp_pc, imem_rsp_data}),
    .rdata (w_fifo_rdata),
    .count (w_fifo_count),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // Fetch FSM: PC advance, redirect handling and draining of stale responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_misalign    <= 1'b0;
    end else begin
      r_misalign    <= w_redirect && (w_raw_target[1:0] != 2'b00);
      r_outstanding <= w_out_next;
      case (r_state)
        IDLE: r_state <= FETCH;
        FETCH: begin
          if (w_redirect) begin
            r_pc <= w_target;
            if (w_out_next != '0) r_state <= DRAIN;
          end else if (w_req_hs) begin
            r_pc <= r_pc + 32'd4;
          end
        end
        DRAIN: begin
          if (w_redirect) begin
            r_pc <= w_target;
          end else if (w_out_next == '0) begin
            r_state <= FETCH;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic [1:0]  pc_src;
  logic [31:0] pc_target;
  logic [31:0] alu_result;
  logic        misalign_err;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4),
    .pc_src         (pc_src),
    .pc_target      (pc_target),
    .alu_result     (alu_result),
    .misalign_err   (misalign_err)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_hs     = 0;
  int          n_consumed = 0;
  logic [31:0] mem_q [$];
  logic [31:0] exp_pc;
  logic [31:0] exp_req_addr;
  logic        exp_mis;
  logic        prev_stall;
  logic [31:0] prev_addr;
  logic [31:0] last_pc;
  logic        mem_hold;
  logic        rand_ready;
  logic        rand_rsp;
  logic [31:0] held_instr;
  logic [31:0] held_pc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1234};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: observe at negedge against the reference, then drive memory after posedge.
  task automatic tick();
    logic        redir;
    logic [31:0] tgt;
    @(negedge clk);
    chk("misalign_err", 32'(misalign_err), 32'(exp_mis));
    if (prev_stall) begin
      chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
      chk("req_hold_addr", imem_req_addr, prev_addr);
    end
    if (imem_req_valid)
      chk("credit", 32'((mem_q.size() + (imem_rsp_valid ? 1 : 0)) < DEPTH), 32'd1);
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_req_addr);
      mem_q.push_back(imem_req_addr);
      exp_req_addr = exp_req_addr + 32'd4;
      n_hs++;
    end
    if (instr_valid && instr_ready) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr", instr, memf(exp_pc));
      chk("pc_plus4", instr_pc_plus4, exp_pc + 32'd4);
      last_pc = instr_pc;
      exp_pc  = exp_pc + 32'd4;
      n_consumed++;
    end
    redir   = (pc_src == 2'b01) || (pc_src == 2'b10);
    tgt     = (pc_src == 2'b10) ? (alu_result & ~32'h1) : pc_target;
    exp_mis = redir && (tgt[1:0] != 2'b00);
    if (redir) begin
      exp_pc       = {tgt[31:2], 2'b00};
      exp_req_addr = {tgt[31:2], 2'b00};
    end
    prev_stall = imem_req_valid && !imem_req_ready && !redir;
    prev_addr  = imem_req_addr;
    @(posedge clk);
    #1;
    if (!mem_hold && mem_q.size() > 0 && (!rand_rsp || $urandom_range(0, 2) != 0)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    if (rand_ready) imem_req_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    pc_src         = 2'b00;
    imem_rsp_valid = 1'b0;
    mem_q.delete();
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_pc_plus4", instr_pc_plus4, 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    exp_pc       = RST_PC;
    exp_req_addr = RST_PC;
    exp_mis      = 1'b0;
    prev_stall   = 1'b0;
    rst_n        = 1'b1;
  endtask

  task automatic redirect(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu);
    pc_src     = src;
    pc_target  = tgt;
    alu_result = alu;
    tick();
    pc_src = 2'b00;
  endtask

  task automatic wait_consume(input int n, input string tag);
    int goal;
    int budget;
    goal   = n_consumed + n;
    budget = 80;
    while (n_consumed < goal && budget > 0) begin
      tick();
      budget--;
    end
    chk(tag, 32'(n_consumed >= goal), 32'd1);
  endtask

  task automatic wait_outstanding(input int n, input string tag);
    int budget;
    budget = 40;
    while ((mem_q.size() < n || instr_valid) && budget > 0) begin
      tick();
      budget--;
    end
    chk(tag, 32'(mem_q.size()), 32'(n));
  endtask

  initial begin
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    instr_ready    = 1'b0;
    pc_src         = 2'b00;
    pc_target      = 32'h0;
    alu_result     = 32'h0;
    mem_hold       = 1'b0;
    rand_ready     = 1'b0;
    rand_rsp       = 1'b0;
    last_pc        = 32'h0;
    do_reset();

    // Decode stalled: only FIFO_DEPTH requests may go out, head held stable.
    n_hs = 0;
    repeat (6) tick();
    held_instr = instr;
    held_pc    = instr_pc;
    repeat (6) tick();
    chk("stall_req_count", 32'(n_hs), 32'(DEPTH));
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_instr_valid", 32'(instr_valid), 32'd1);
    chk("stall_instr_hold", instr, held_instr);
    chk("stall_pc_hold", held_pc, RST_PC);
    chk("stall_pc_now", instr_pc, held_pc);

    // Streaming from reset: pcs 0,4,8,... in order.
    instr_ready = 1'b1;
    wait_consume(1, "first_consume");
    chk("first_pc", last_pc, RST_PC);
    wait_consume(6, "stream_consume");

    // Redirect with two requests in flight: both responses dropped.
    mem_hold = 1'b1;
    wait_outstanding(2, "two_outstanding");
    redirect(2'b01, 32'h0000_0100, 32'h0);
    mem_hold = 1'b0;
    while (mem_q.size() > 0 || imem_rsp_valid) begin
      chk("drain_no_req", 32'(imem_req_valid), 32'd0);
      tick();
    end
    wait_consume(1, "after_drain_consume");
    chk("after_drain_pc", last_pc, 32'h0000_0100);

    // jalr targets: low bit cleared, bit 1 set flags a misalignment.
    redirect(2'b10, 32'h0, 32'h0000_0203);
    chk("jalr_misalign_pulse", 32'(misalign_err), 32'd1);
    tick();
    chk("jalr_misalign_clear", 32'(misalign_err), 32'd0);
    redirect(2'b10, 32'h0, 32'h0000_0201);
    chk("jalr_aligned_no_err", 32'(misalign_err), 32'd0);
    wait_consume(1, "jalr_consume");
    chk("jalr_pc", last_pc, 32'h0000_0200);

    // Response landing on the redirect cycle must never reach decode.
    mem_hold = 1'b1;
    wait_outstanding(1, "one_outstanding");
    pc_src         = 2'b01;
    pc_target      = 32'h0000_0300;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = memf(mem_q.pop_front());
    tick();
    pc_src   = 2'b00;
    mem_hold = 1'b0;
    wait_consume(1, "same_cycle_consume");
    chk("same_cycle_pc", last_pc, 32'h0000_0300);

    // Address wrap-around at the top of memory.
    redirect(2'b01, 32'hFFFF_FFF8, 32'h0);
    wait_consume(4, "wrap_consume");
    chk("wrap_pc", last_pc, 32'h0000_0004);

    // Randomized traffic: ready toggling, response gaps, random redirects.
    rand_ready = 1'b1;
    rand_rsp   = 1'b1;
    for (int i = 0; i < 400; i++) begin
      instr_ready = 1'($urandom_range(0, 3) != 0);
      pc_target   = $urandom;
      alu_result  = $urandom;
      if ($urandom_range(0, 11) == 0) pc_src = 2'($urandom_range(0, 3));
      tick();
      pc_src = 2'b00;
    end
    rand_ready     = 1'b0;
    rand_rsp       = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;

    // Reset in the middle of a drain discards everything.
    mem_hold = 1'b1;
    wait_outstanding(2, "pre_reset_outstanding");
    redirect(2'b01, 32'h0000_0400, 32'h0);
    do_reset();
    mem_hold = 1'b0;
    wait_consume(1, "post_reset_consume");
    chk("post_reset_pc", last_pc, RST_PC);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
